// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Purpose  : Shared AES constants and types: round count, Rcon table, S-box,
//            key-schedule FSM state enum and 32-bit word type.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_NR = 10;

  typedef logic [31:0] aes_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } kx_state_t;

  // Round constants indexed by round number 1..10; the unused slots are zero
  // so any 4-bit index is a legal lookup.
  localparam logic [7:0] AES_RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // RotWord: cyclic left rotation by one byte ({a0,a1,a2,a3} -> {a1,a2,a3,a0}).
  function automatic aes_word_t aes_rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Purpose  : Combinational AES forward S-box, one byte in, one byte out.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  assign byte_o = AES_SBOX[byte_i];

endmodule
`default_nettype wire

// File: rtl/aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expand
// Purpose  : Iterative AES-128 key schedule. Captures a 128-bit key, computes
//            one round key per iteration through a shared SubWord datapath and
//            streams rounds 0..10 out over a valid/ready handshake.
// Options  : AES_KEY_STORE_EN - keep all 11 round keys in a readable register
//            array (registered read port rd_addr/rd_data). When undefined,
//            rd_data is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] K,
  input  logic         val_K,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         val_round_key,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_data
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  kx_state_t    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;

  aes_word_t    w_rot;
  aes_word_t    w_sub;
  aes_word_t    w_temp;
  aes_word_t    w0_n, w1_n, w2_n, w3_n;
  logic [3:0]   rcon_idx;

  // SubWord(RotWord(w3)) using four shared S-box lookups.
  assign w_rot = aes_rot_word(key_q[31:0]);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      aes_sbox u_sbox (
        .byte_i (w_rot[8*gi +: 8]),
        .byte_o (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  // The key being computed is round idx+1, so its Rcon is taken one ahead.
  assign rcon_idx = idx_q + 4'd1;
  assign w_temp   = w_sub ^ {AES_RCON[rcon_idx], 24'h000000};
  assign w0_n     = key_q[127:96] ^ w_temp;
  assign w1_n     = key_q[95:64]  ^ w0_n;
  assign w2_n     = key_q[63:32]  ^ w1_n;
  assign w3_n     = key_q[31:0]   ^ w2_n;

  // Next-state, working-key and round-index update.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (val_K) begin
          key_d   = K;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          state_d = (idx_q == LAST_IDX) ? DONE : CALC;
        end
      end
      CALC: begin
        key_d   = {w0_n, w1_n, w2_n, w3_n};
        idx_d   = idx_q + 4'd1;
        state_d = EMIT;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working key and round index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  assign round_key     = key_q;
  assign round_idx     = idx_q;
  assign val_round_key = (state_q == EMIT);
  assign busy          = (state_q == EMIT) || (state_q == CALC);
  assign done          = (state_q == DONE);

`ifdef AES_KEY_STORE_EN
  logic [127:0] store_q [0:10];
  logic [127:0] rd_data_q;
  logic [127:0] rd_mux;
  logic         store_we;

  // A key is stored on the same edge that moves it into EMIT.
  assign store_we = ((state_q == IDLE) && val_K) || (state_q == CALC);

  // Read mux; addresses beyond the last round fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i <= 10; i++) begin
      if (rd_addr == 4'(i)) begin
        rd_mux = store_q[i];
      end
    end
  end

  // Round-key store writes and registered read port.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= 10; i++) begin
        store_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i <= 10; i++) begin
        if (store_we && (idx_d == 4'(i))) begin
          store_q[i] <= key_d;
        end
      end
      rd_data_q <= rd_mux;
    end
  end

  assign rd_data = rd_data_q;
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_expand
// Purpose  : Self-checking bench for aes_key_expand. The reference key
//            schedule is built from GF(2^8) arithmetic (S-box derived from the
//            field inverse plus affine map, Rcon from repeated doubling).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] K;
  logic         val_K;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         val_round_key;
  logic         rk_ready = 1'b1;
  logic         busy;
  logic         done;
  logic [3:0]   rd_addr;
  logic [127:0] rd_data;

  aes_key_expand dut (
    .clk           (clk),
    .reset         (reset),
    .K             (K),
    .val_K         (val_K),
    .round_key     (round_key),
    .round_idx     (round_idx),
    .val_round_key (val_round_key),
    .rk_ready      (rk_ready),
    .busy          (busy),
    .done          (done),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_keys [11];
  bit           mon_en     = 1'b0;
  int           arm_cnt    = 0;
  bit           stall_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++) begin
      if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] a);
    logic [7:0] b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- ready driver: optional random stalls of 0..7 cycles ----
  int stall_left = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      rk_ready = 1'b1;
    end else if (stall_left > 0) begin
      rk_ready   = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      rk_ready   = 1'b1;
      stall_left = $urandom_range(0, 7);
    end
  end

  // ---------------- compare process ----------------
  int           exp_idx   = 0;
  int           transfers = 0;
  int           seen_arm  = 0;
  bit           acc_prev  = 1'b0;
  bit           stall_prev = 1'b0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;

  always @(negedge clk) begin
    if (arm_cnt != seen_arm) begin
      seen_arm   = arm_cnt;
      exp_idx    = 0;
      transfers  = 0;
      acc_prev   = 1'b0;
      stall_prev = 1'b0;
    end
    if (mon_en) begin
      if (acc_prev) chk("val_drop_after_accept", 128'(val_round_key), 128'd0);
      if (val_round_key) begin
        if (exp_idx > 10) begin
          chk("extra_transfer", 128'(exp_idx), 128'd10);
        end else begin
          chk("round_idx", 128'(round_idx), 128'(exp_idx));
          chk("round_key", round_key, exp_keys[exp_idx]);
        end
        chk("busy_in_emit", 128'(busy), 128'd1);
        if (stall_prev) begin
          chk("stall_key_stable", round_key, held_key);
          chk("stall_idx_stable", 128'(round_idx), 128'(held_idx));
        end
      end
      if (done) chk("transfers_at_done", 128'(transfers), 128'd11);
      acc_prev   = val_round_key && rk_ready;
      stall_prev = val_round_key && !rk_ready;
      held_key   = round_key;
      held_idx   = round_idx;
      if (acc_prev) begin
        exp_idx   = exp_idx + 1;
        transfers = transfers + 1;
      end
    end
  end

  // Run one expansion. n is the cycle counter just after the capture edge,
  // dcyc the counter value in the cycle done is seen. inject_at >= 0 pulses
  // val_K with a different key while that round is being offered.
  task automatic run_key(input logic [127:0] key, input bit stall, input int inject_at,
                         output int n, output int dcyc);
    bit ok       = 1'b0;
    bit injected = 1'b0;
    build_model(key);
    arm_cnt    = arm_cnt + 1;
    stall_mode = stall;
    mon_en     = 1'b1;
    dcyc       = -1;
    @(posedge clk); #1;
    K     = key;
    val_K = 1'b1;
    @(posedge clk); #1;
    n     = cyc;
    val_K = 1'b0;
    K     = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("first_cycle_valid", 128'(val_round_key), 128'd1);
    chk("first_cycle_busy", 128'(busy), 128'd1);
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        dcyc = cyc;
        ok   = 1'b1;
        break;
      end
      if (!injected && inject_at >= 0 && val_round_key && round_idx == 4'(inject_at)) begin
        injected = 1'b1;
        K        = ~key;
        val_K    = 1'b1;
        @(posedge clk); #1;
        val_K    = 1'b0;
      end
      @(negedge clk);
    end
    if (!ok) chk("done_timeout", 128'd0, 128'd1);
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'd0);
    chk("idle_not_busy", 128'(busy), 128'd0);
    stall_mode = 1'b0;
  endtask

  task automatic read_store(input logic [3:0] a, input logic [127:0] exp, input string name);
    @(posedge clk); #1;
    rd_addr = a;
    @(posedge clk); #1;
    chk(name, rd_data, exp);
  endtask

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  initial begin
    int n;
    int dcyc;
    int guard;
    logic [127:0] rk;

    reset   = 1'b1;
    val_K   = 1'b0;
    K       = '0;
    rd_addr = '0;
    for (int i = 0; i < 256; i++) sb[i] = sbox_m(8'(i));
    chk("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sb[8'h53]), 128'hed);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_round_key", round_key, 128'd0);
    chk("reset_round_idx", 128'(round_idx), 128'd0);
    chk("reset_val", 128'(val_round_key), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_rd_data", rd_data, 128'd0);
    reset = 1'b0;

    // FIPS-197 key, ready tied high; done lands 21 edges after capture,
    // i.e. in cycle n+22 counting the capture cycle as n.
    run_key(FIPS_KEY, 1'b0, -1, n, dcyc);
    chk("model_fips_r1", exp_keys[1], FIPS_R1);
    chk("model_fips_r10", exp_keys[10], FIPS_R10);
    chk("fips_done_latency", 128'(dcyc - n), 128'd21);
`ifdef AES_KEY_STORE_EN
    read_store(4'd10, FIPS_R10, "store_rd_10");
    read_store(4'd12, 128'd0, "store_rd_12");
    read_store(4'd0, FIPS_KEY, "store_rd_0");
`else
    read_store(4'd10, 128'd0, "rd_data_tied_zero");
`endif

    // All-zero key.
    run_key(128'd0, 1'b0, -1, n, dcyc);
    chk("model_zero_r1", exp_keys[1], ZERO_R1);

    // Random keys under random backpressure.
    for (int k = 0; k < 3; k++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      run_key(rk, 1'b1, -1, n, dcyc);
`ifdef AES_KEY_STORE_EN
      for (int a = 0; a < 11; a++) read_store(4'(a), exp_keys[a], "store_rd_random");
`endif
    end

    // Second key strobed while round 4 is offered must be ignored.
    rk = {$urandom, $urandom, $urandom, $urandom};
    run_key(rk, 1'b0, 4, n, dcyc);
    chk("inject_done_latency", 128'(dcyc - n), 128'd21);

    // Reset in the CALC cycle producing round 6, with a lost val_K alongside.
    rk = {$urandom, $urandom, $urandom, $urandom};
    build_model(rk);
    arm_cnt = arm_cnt + 1;
    mon_en  = 1'b1;
    @(posedge clk); #1;
    K     = rk;
    val_K = 1'b1;
    @(posedge clk); #1;
    val_K = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(val_round_key && round_idx == 4'd5) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 100) chk("reach_round5_timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    chk("calc_val_low", 128'(val_round_key), 128'd0);
    mon_en = 1'b0;
    reset  = 1'b1;
    val_K  = 1'b1;
    K      = ~rk;
    @(posedge clk); #1;
    reset = 1'b0;
    val_K = 1'b0;
    chk("midreset_round_key", round_key, 128'd0);
    chk("midreset_round_idx", 128'(round_idx), 128'd0);
    chk("midreset_val", 128'(val_round_key), 128'd0);
    chk("midreset_busy", 128'(busy), 128'd0);
    chk("midreset_done", 128'(done), 128'd0);
    chk("midreset_rd_data", rd_data, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("lost_val_K", 128'(val_round_key), 128'd0);

    rk = {$urandom, $urandom, $urandom, $urandom};
    run_key(rk, 1'b0, -1, n, dcyc);
    chk("restart_done_latency", 128'(dcyc - n), 128'd21);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
